// File: rtl/mips_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU operation and
// result-class codes, the execute FSM state type and an overflow helper.
package mips_pkg;

  localparam int REG_W      = 32;
  localparam int ALU_OP_W   = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int REG_ADDR_W = 5;
  localparam int SHAMT_W    = 5;

  localparam logic [REG_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'h00;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'h20;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP = 8'h22;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP = 8'h24;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP  = 8'h25;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP = 8'h26;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP = 8'h7C;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } ex_state_e;

  // Signed overflow of a two's-complement add: operands agree in sign, result
  // does not. For a subtract the caller passes the inverted subtrahend sign.
  function automatic logic add_ovf(input logic a_sign, input logic b_sign,
                                   input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/ex_shifter.sv
// Iterative left shifter: one bit per step.
//   load/load_val/load_shamt : capture operand and shift amount
//   step                     : perform one 1-bit shift while count is nonzero
//   next_val                 : value after the step taken this cycle
//   done                     : the step taken this cycle is the last one
module ex_shifter
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [REG_W-1:0]   load_val,
  input  logic [SHAMT_W-1:0] load_shamt,
  input  logic               step,
  output logic [REG_W-1:0]   next_val,
  output logic               done
);

  logic [REG_W-1:0]   val_r;
  logic [SHAMT_W-1:0] cnt_r;

  // Operand and remaining-shift counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= ZERO_WORD;
      cnt_r <= 5'd0;
    end else if (load) begin
      val_r <= load_val;
      cnt_r <= load_shamt;
    end else if (step && (cnt_r != 5'd0)) begin
      val_r <= {val_r[REG_W-2:0], 1'b0};
      cnt_r <= cnt_r - 5'd1;
    end else begin
      val_r <= val_r;
      cnt_r <= cnt_r;
    end
  end

  assign next_val = {val_r[REG_W-2:0], 1'b0};
  // A zero count can never be stepped; treating it as done keeps the FSM from
  // stalling forever should it ever be reached.
  assign done     = (cnt_r <= 5'd1);

endmodule

// File: rtl/ex_unit.sv
// Execute stage: single-cycle ALU (ADD/SUB/AND/OR/XOR), iterative SLL and a
// valid/ready result register toward MEM.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : decoded bundle handshake
//   aluop_i, alusel_i        : operation, result class (passed through)
//   reg1_i, reg2_i           : source operands
//   wd_i, wreg_i             : destination register and write request
//   out_valid/out_ready      : result handshake toward MEM
//   wdata_o, wd_o, wreg_o,
//   alusel_o, ovf_o          : registered result bundle
//   stallreq_o               : high while an SLL is iterating
module ex_unit
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   aluop_i,
  input  logic [ALU_SEL_W-1:0]  alusel_i,
  input  logic [REG_W-1:0]      reg1_i,
  input  logic [REG_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_W-1:0]      wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [ALU_SEL_W-1:0]  alusel_o,
  output logic                  ovf_o,
  output logic                  stallreq_o
);

  ex_state_e          state_r;
  logic               in_ready_s;
  logic               accept_s;
  logic               is_sll_s;
  logic               alu_def_s;
  logic               alu_ovf_s;
  logic               alu_wreg_s;
  logic [REG_W-1:0]   alu_res_s;
  logic [REG_W-1:0]   sum_s;
  logic [REG_W-1:0]   diff_s;
  logic [REG_W-1:0]   shf_next_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               shf_done_s;
  logic               shf_load_s;
  logic               shf_step_s;

  // Accept in IDLE, or in OUT when the held result drains on the same edge.
  always_comb begin
    if (rst) begin
      in_ready_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      in_ready_s = 1'b1;
    end else if (state_r == ST_OUT) begin
      in_ready_s = out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign in_ready   = in_ready_s;
  assign stallreq_o = !rst && (state_r == ST_SHIFT);
  assign accept_s   = in_valid && in_ready_s;
  assign shamt_s    = reg1_i[SHAMT_W-1:0];
  assign sum_s      = reg1_i + reg2_i;
  assign diff_s     = reg1_i - reg2_i;

  // Single-cycle ALU result; SLL yields reg2 here for the zero-shift case.
  always_comb begin
    alu_res_s = ZERO_WORD;
    alu_ovf_s = 1'b0;
    alu_def_s = 1'b1;
    is_sll_s  = 1'b0;
    case (aluop_i)
      EXE_ADD_OP: begin
        alu_res_s = sum_s;
        alu_ovf_s = add_ovf(reg1_i[REG_W-1], reg2_i[REG_W-1], sum_s[REG_W-1]);
      end
      EXE_SUB_OP: begin
        alu_res_s = diff_s;
        alu_ovf_s = add_ovf(reg1_i[REG_W-1], ~reg2_i[REG_W-1], diff_s[REG_W-1]);
      end
      EXE_AND_OP: alu_res_s = reg1_i & reg2_i;
      EXE_OR_OP:  alu_res_s = reg1_i | reg2_i;
      EXE_XOR_OP: alu_res_s = reg1_i ^ reg2_i;
      EXE_SLL_OP: begin
        alu_res_s = reg2_i;
        is_sll_s  = 1'b1;
      end
      default: begin
        // NOP and every undefined code: an empty, non-writing beat.
        alu_res_s = ZERO_WORD;
        alu_ovf_s = 1'b0;
        alu_def_s = 1'b0;
      end
    endcase
  end

  assign alu_wreg_s = wreg_i && alu_def_s && !alu_ovf_s;
  assign shf_load_s = accept_s && is_sll_s;
  assign shf_step_s = (state_r == ST_SHIFT);

  ex_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (shf_load_s),
    .load_val   (reg2_i),
    .load_shamt (shamt_s),
    .step       (shf_step_s),
    .next_val   (shf_next_s),
    .done       (shf_done_s)
  );

  // Execute FSM and registered result bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      out_valid <= 1'b0;
      wdata_o   <= ZERO_WORD;
      wd_o      <= 5'd0;
      wreg_o    <= 1'b0;
      alusel_o  <= 3'd0;
      ovf_o     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_OUT: begin
          if (accept_s) begin
            wd_o     <= wd_i;
            alusel_o <= alusel_i;
            if (is_sll_s && (shamt_s != 5'd0)) begin
              state_r   <= ST_SHIFT;
              out_valid <= 1'b0;
              wreg_o    <= wreg_i;
              ovf_o     <= 1'b0;
            end else begin
              state_r   <= ST_OUT;
              out_valid <= 1'b1;
              wdata_o   <= alu_res_s;
              wreg_o    <= alu_wreg_s;
              ovf_o     <= alu_ovf_s;
            end
          end else if ((state_r == ST_OUT) && out_ready) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_SHIFT: begin
          if (shf_done_s) begin
            state_r   <= ST_OUT;
            out_valid <= 1'b1;
            wdata_o   <= shf_next_s;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_unit.sv
// Self-checking bench for ex_unit: directed scenarios plus randomized traffic
// checked against a behavioural result/latency model and a result queue.
module tb_ex_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        wreg_i, wreg_o, ovf_o, stallreq_o;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i, alusel_o;
  logic [31:0] reg1_i, reg2_i, wdata_o;
  logic [4:0]  wd_i, wd_o;

  ex_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
    .wd_i(wd_i), .wreg_i(wreg_i), .out_valid(out_valid), .out_ready(out_ready),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o), .alusel_o(alusel_o),
    .ovf_o(ovf_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [2:0]  alusel;
    logic        ovf;
    int          lat;
    int          acc;
    bit          started;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   acc_flag = 1'b0;
  bit   rdy_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, req);
    end
  endtask

  // Reference: result from plain arithmetic; lat = cycles from accept to result.
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] wd,
                                 input logic wr, input logic [2:0] sel);
    exp_t   e;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.wd = wd; e.alusel = sel; e.ovf = 1'b0; e.wdata = 32'd0;
    e.lat = 1; e.acc = 0; e.started = 1'b0; e.wreg = wr;
    case (op)
      8'h20: begin r = sa + sb; e.wdata = a + b; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      8'h22: begin r = sa - sb; e.wdata = a - b; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      8'h24: e.wdata = a & b;
      8'h25: e.wdata = a | b;
      8'h26: e.wdata = a ^ b;
      8'h7C: begin e.wdata = b << a[4:0]; e.lat = int'(a[4:0]) + 1; end
      default: e.wreg = 1'b0;
    endcase
    if (e.ovf) e.wreg = 1'b0;
    return e;
  endfunction

  // Observe the current cycle against the model, then advance one edge.
  task automatic tick();
    bit   exp_stall;
    logic exp_rdy;
    exp_t e;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    if (rst) begin
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("rst_stallreq", {31'd0, stallreq_o}, 32'd0);
      q.delete();
    end else begin
      if (q.size() > 0 && !q[0].started && out_valid) begin
        check_eq("latency", cyc - q[0].acc, q[0].lat);
        q[0].started = 1'b1;
      end
      if (q.size() > 0 && !q[0].started && (cyc - q[0].acc) > q[0].lat) begin
        check_eq("result_timeout", {31'd0, out_valid}, 32'd1);
        void'(q.pop_front());
      end
      exp_stall = (q.size() > 0) && !q[0].started && ((cyc - q[0].acc) < q[0].lat);
      if (q.size() > 0 && q[0].started) exp_rdy = out_ready;
      else if (exp_stall)               exp_rdy = 1'b0;
      else                              exp_rdy = 1'b1;
      check_eq("stallreq", {31'd0, stallreq_o}, {31'd0, exp_stall});
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          check_eq("wdata", wdata_o, q[0].wdata);
          check_eq("wd", {27'd0, wd_o}, {27'd0, q[0].wd});
          check_eq("wreg", {31'd0, wreg_o}, {31'd0, q[0].wreg});
          check_eq("alusel", {29'd0, alusel_o}, {29'd0, q[0].alusel});
          check_eq("ovf", {31'd0, ovf_o}, {31'd0, q[0].ovf});
        end
      end
      if (out_valid && out_ready && q.size() > 0 && q[0].started) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = model(aluop_i, reg1_i, reg2_i, wd_i, wreg_i, alusel_i);
        e.acc = cyc;
        q.push_back(e);
        acc_flag = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_bundle(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wd, input logic wr, input logic [2:0] sel);
    in_valid = 1'b1; aluop_i = op; reg1_i = a; reg2_i = b;
    wd_i = wd; wreg_i = wr; alusel_i = sel;
  endtask

  // Present a bundle until accepted (bounded), leaving in_valid low.
  task automatic send(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wd, input logic wr, input logic [2:0] sel);
    int n;
    n = 0;
    set_bundle(op, a, b, wd, wr, sel);
    acc_flag = 1'b0;
    while (!acc_flag && n < 60) begin
      tick();
      n++;
    end
    if (!acc_flag) check_eq("accept_timeout", {31'd0, acc_flag}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [7:0]  ops [7] = '{8'h00, 8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h7C};
  logic [31:0] hold_w;
  logic [7:0]  rop;
  int          nstall;
  int          guard;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    aluop_i = 8'h00; alusel_i = 3'd0; reg1_i = 32'd0; reg2_i = 32'd0;
    wd_i = 5'd0; wreg_i = 1'b0;
    idle(2);
    rst = 1'b0;
    check_eq("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("reset_wdata", wdata_o, 32'd0);
    check_eq("reset_wd", {27'd0, wd_o}, 32'd0);
    check_eq("reset_wreg", {31'd0, wreg_o}, 32'd0);
    check_eq("reset_alusel", {29'd0, alusel_o}, 32'd0);
    check_eq("reset_ovf", {31'd0, ovf_o}, 32'd0);

    // Signed overflow on ADD suppresses the write.
    send(8'h20, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 3'b100);
    check_eq("add_ovf_wdata", wdata_o, 32'h8000_0000);
    check_eq("add_ovf_flag", {31'd0, ovf_o}, 32'd1);
    check_eq("add_ovf_wreg", {31'd0, wreg_o}, 32'd0);
    idle(1);

    send(8'h25, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1'b1, 3'b001);
    check_eq("or_valid", {31'd0, out_valid}, 32'd1);
    check_eq("or_wdata", wdata_o, 32'h0000_FFFF);
    check_eq("or_wd", {27'd0, wd_o}, 32'd5);
    check_eq("or_wreg", {31'd0, wreg_o}, 32'd1);
    idle(1);

    // SLL by 4: four stall cycles, then the shifted value.
    send(8'h7C, 32'h0000_0004, 32'h0000_0003, 5'd7, 1'b1, 3'b010);
    nstall = 0;
    while (stallreq_o && nstall < 40) begin
      tick();
      nstall++;
    end
    check_eq("sll_stall_cycles", nstall, 32'd4);
    check_eq("sll_wdata", wdata_o, 32'h0000_0030);
    idle(1);

    // Back-pressure on an XOR result, then same-edge accept of a queued SUB.
    out_ready = 1'b0;
    send(8'h26, 32'hA5A5_0000, 32'h0F0F_1234, 5'd9, 1'b1, 3'b001);
    hold_w = wdata_o;
    set_bundle(8'h22, 32'd5, 32'd7, 5'd10, 1'b1, 3'b100);
    for (int i = 0; i < 3; i++) tick();
    check_eq("hold_wdata", wdata_o, hold_w);
    check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    acc_flag = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("b2b_accept", {31'd0, acc_flag}, 32'd1);
    check_eq("sub_wdata", wdata_o, 32'hFFFF_FFFE);
    idle(1);

    // Reset during the second SHIFT cycle of a 10-bit shift discards it.
    send(8'h7C, 32'd10, 32'd1, 5'd4, 1'b1, 3'b010);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_shift_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_shift_stall", {31'd0, stallreq_o}, 32'd0);
    check_eq("rst_shift_wdata", wdata_o, 32'd0);
    idle(15);

    // Undefined opcode: one non-writing beat.
    send(8'h55, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6, 1'b1, 3'b001);
    check_eq("undef_valid", {31'd0, out_valid}, 32'd1);
    check_eq("undef_wdata", wdata_o, 32'd0);
    check_eq("undef_wreg", {31'd0, wreg_o}, 32'd0);
    check_eq("undef_ovf", {31'd0, ovf_o}, 32'd0);
    idle(1);

    // Randomized traffic with random back-pressure and bubbles.
    rdy_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 7) == 0) rop = 8'($urandom);
      else                           rop = ops[$urandom_range(0, 6)];
      send(rop, pick32(), pick32(), 5'($urandom), 1'($urandom),
           3'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("drain", q.size(), 32'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have port clk  in  1  rising-edge clock.
REQ-002 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-003 SHALL have port in_valid  in  1  decoded bundle present.
REQ-004 SHALL have port in_ready  out  1  bundle accepted when in_valid&in_ready at clk edge.
REQ-005 SHALL have port aluop_i  in  8  operation: NOP 0x00, ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, SLL 0x7C.
REQ-006 SHALL have port alusel_i  in  3  result class; carried to alusel_o, not used for operation selection.
REQ-007 SHALL have ports reg1_i and reg2_i  in  32 each  source operands, register value or zero-extended immediate.
REQ-008 SHALL have ports wd_i  in  5  destination register, and wreg_i  in  1  write request.
REQ-009 SHALL have port out_valid  out  1  result present toward MEM.
REQ-010 SHALL have port out_ready  in  1  MEM accepts result when out_valid&out_ready at clk edge.
REQ-011 SHALL have ports wdata_o  out  32, wd_o  out  5, wreg_o  out  1, alusel_o  out  3  registered result bundle.
REQ-012 SHALL have port ovf_o  out  1  signed overflow flag, valid with out_valid.
REQ-013 SHALL have port stallreq_o  out  1  high while an accepted SLL is still iterating.

Function
REQ-014 SHALL implement states IDLE, SHIFT, OUT; all outputs are registered except in_ready and stallreq_o.
REQ-015 SHALL drive in_ready=1 in IDLE, in_ready=out_ready in OUT, and in_ready=0 in SHIFT.
REQ-016 SHALL, on accepting a non-SLL op, compute the result and enter OUT on the next edge (1-cycle latency).
REQ-017 SHALL compute ADD/SUB as 32-bit two's-complement reg1±reg2, wraparound; AND/OR/XOR bitwise on reg1, reg2.
REQ-018 SHALL set ovf_o=1 and force wreg_o=0 when ADD/SUB signed overflow occurs (operand signs agree, result sign differs; for SUB use ~reg2 sign).
REQ-019 SHALL compute SLL as reg2_i << reg1_i[4:0], shifting one bit per cycle in SHIFT; latency = shamt+1 cycles; shamt 0 goes directly to OUT with wdata=reg2_i.
REQ-020 SHALL drive stallreq_o=1 in every SHIFT cycle and 0 otherwise.
REQ-021 SHALL treat NOP and any undefined aluop as wdata_o=0, wreg_o=0, ovf_o=0, still producing one out_valid beat.
REQ-022 SHALL otherwise pass wd_i, wreg_i, alusel_i unchanged to wd_o, wreg_o, alusel_o.
REQ-023 SHALL hold all result outputs stable in OUT while out_ready=0.
REQ-024 SHALL, in OUT with out_ready=1 and in_valid=1, accept the new bundle in the same edge (back-to-back, no bubble); with in_valid=0, return to IDLE with out_valid=0.
REQ-025 SHALL ignore in_valid while in SHIFT; the upstream holds its bundle via stallreq_o.

Reset
REQ-026 SHALL, when rst=1 at a clk edge, enter IDLE and clear out_valid, wdata_o, wd_o, wreg_o, alusel_o, ovf_o, shift counter to 0, regardless of state.
REQ-027 SHALL drive in_ready=0 and stallreq_o=0 while rst=1; an in-flight SLL or held result is discarded.

Structure
REQ-028 SHALL take aluop/alusel codes, ZeroWord and bus widths from the shared package mips_pkg; no literal opcode values in the module body.
REQ-029 SHALL place the iterative shifter (load, step, done) in one sub-module ex_shifter; ALU and FSM stay in ex_unit.

Verification
REQ-030 SHALL cover ADD 0x7FFFFFFF+1, wd=3, wreg=1 -> next cycle wdata=0x80000000, ovf_o=1, wreg_o=0.
REQ-031 SHALL cover OR 0x0000F0F0|0x00000F0F, wd=5 -> one cycle later out_valid=1, wdata=0x0000FFFF, wd_o=5, wreg_o=1.
REQ-032 SHALL cover SLL reg1=4, reg2=0x00000003 -> stallreq_o high 4 cycles, in_ready=0, then wdata=0x00000030.
REQ-033 SHALL cover out_ready=0 for 3 cycles after an XOR result -> outputs unchanged, in_ready=0; out_ready=1 with queued SUB 5-7 -> same-edge accept, next wdata=0xFFFFFFFE.
REQ-034 SHALL cover rst asserted on the 2nd SHIFT cycle of SLL shamt 10 -> next edge IDLE, out_valid=0, stallreq_o=0, no result emitted.
REQ-035 SHALL cover aluop 0x55 with wreg_i=1 -> one beat, wdata=0, wreg_o=0, ovf_o=0.
